// File: rtl/cache_pkg.sv
// Shared types and tree-PLRU helpers for the n-way cache controller.
// The PLRU helpers work on up to 8 ways; callers zero-extend and truncate.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPARE   = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_FILL      = 2'd3
  } state_e;

  localparam int MAX_LEVELS = 3;

  function automatic int plru_levels(input int ways);
    if (ways >= 8) return 3;
    else if (ways >= 4) return 2;
    else return 1;
  endfunction

  // Walk from the root: a 0 bit sends the victim search to the lower half.
  function automatic int plru_victim(input logic [31:0] bits, input int ways);
    int node;
    int lv;
    node = 0;
    lv   = plru_levels(ways);
    for (int lvl = 0; lvl < MAX_LEVELS; lvl++) begin
      if (lvl < lv) node = 2 * node + 1 + int'(bits[node]);
    end
    return node - (ways - 1);
  endfunction

  // Every node on the accessed path is made to point at the other subtree.
  function automatic logic [31:0] plru_update(input logic [31:0] bits, input int way,
                                              input int ways);
    logic [31:0] nb;
    logic [31:0] w;
    int          node;
    int          lv;
    nb   = bits;
    w    = 32'(way);
    node = 0;
    lv   = plru_levels(ways);
    for (int lvl = 0; lvl < MAX_LEVELS; lvl++) begin
      if (lvl < lv) begin
        nb[node] = ~w[lv-1-lvl];
        node     = 2 * node + 1 + int'(w[lv-1-lvl]);
      end
    end
    return nb;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU: victim selection and post-access update for one set.
module plru_tree
  import cache_pkg::*;
#(
  parameter  int WAYS = 4,
  localparam int WIDX = $clog2(WAYS)
) (
  input  logic [WAYS-2:0] plru_bits,
  input  logic [WIDX-1:0] access_way,
  output logic [WIDX-1:0] victim,
  output logic [WAYS-2:0] plru_next
);

  assign victim    = WIDX'(plru_victim(32'(plru_bits), WAYS));
  assign plru_next = (WAYS-1)'(plru_update(32'(plru_bits), int'(access_way), WAYS));

endmodule

// File: rtl/nway_cache_control.sv
// Set-associative cache controller: hit/miss compare, dirty writeback, line fill.
// Outputs decode from the current state and the addressed set's tag-array flags.
module nway_cache_control
  import cache_pkg::*;
#(
  parameter  int WAYS = 4,
  localparam int WIDX = $clog2(WAYS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  output logic            mem_resp,
  input  logic [WAYS-1:0] hit_way,
  input  logic [WAYS-1:0] valid_way,
  input  logic [WAYS-1:0] dirty_way,
  input  logic [WAYS-2:0] plru_out,
  output logic [WAYS-2:0] plru_in,
  output logic            load_plru,
  output logic [WIDX-1:0] way_sel,
  output logic [WAYS-1:0] load_data,
  output logic            data_in_sel,
  output logic [WAYS-1:0] load_tag,
  output logic [WAYS-1:0] load_valid,
  output logic [WAYS-1:0] load_dirty,
  output logic            dirty_in,
  output logic            pmem_addr_sel,
  output logic            pmem_read,
  output logic            pmem_write,
  input  logic            pmem_resp
);

  state_e          state_q, state_d;
  logic [WIDX-1:0] victim_q, victim_d;

  logic            req;
  logic            hit;
  logic [WIDX-1:0] hit_idx;
  logic [WIDX-1:0] inv_idx;
  logic            any_inv;
  logic [WIDX-1:0] plru_victim_w;
  logic [WIDX-1:0] miss_victim;
  logic [WAYS-2:0] plru_upd;
  logic [WAYS-1:0] hit_oh;
  logic [WAYS-1:0] victim_oh;

  assign req = mem_read | mem_write;
  assign hit = |hit_way;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit_idx = '0;
    inv_idx = '0;
    any_inv = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_way[i]) hit_idx = WIDX'(i);
      if (!valid_way[i]) begin
        inv_idx = WIDX'(i);
        any_inv = 1'b1;
      end
    end
  end

  plru_tree #(.WAYS(WAYS)) u_plru (
    .plru_bits (plru_out),
    .access_way(hit_idx),
    .victim    (plru_victim_w),
    .plru_next (plru_upd)
  );

  assign miss_victim = any_inv ? inv_idx : plru_victim_w;
  assign hit_oh      = WAYS'(1) << hit_idx;
  assign victim_oh   = WAYS'(1) << victim_q;

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    mem_resp      = 1'b0;
    plru_in       = '0;
    load_plru     = 1'b0;
    way_sel       = '0;
    load_data     = '0;
    data_in_sel   = 1'b0;
    load_tag      = '0;
    load_valid    = '0;
    load_dirty    = '0;
    dirty_in      = 1'b0;
    pmem_addr_sel = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          mem_resp  = 1'b1;
          way_sel   = hit_idx;
          load_plru = 1'b1;
          plru_in   = plru_upd;
          if (mem_write) begin
            load_data   = hit_oh;
            load_dirty  = hit_oh;
            data_in_sel = 1'b1;
            dirty_in    = 1'b1;
          end
          state_d = ST_IDLE;
        end else begin
          victim_d = miss_victim;
          state_d  = dirty_way[miss_victim] ? ST_WRITEBACK : ST_FILL;
        end
      end
      ST_WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim_q;
        if (pmem_resp) state_d = ST_FILL;
      end
      ST_FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          load_data  = victim_oh;
          load_tag   = victim_oh;
          load_valid = victim_oh;
          load_dirty = victim_oh;
          state_d    = ST_COMPARE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

endmodule
